// File: rtl/switch_box_pkg.sv
// Shared constants and helpers for the runtime-configurable routing switch box.
package switch_box_pkg;

  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_OFF    = 3'd0;
  localparam logic [SEL_W-1:0] SEL_TOP    = 3'd1;
  localparam logic [SEL_W-1:0] SEL_RIGHT  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_BOTTOM = 3'd3;
  localparam logic [SEL_W-1:0] SEL_LEFT   = 3'd4;

  localparam int unsigned SIDE_TOP    = 0;
  localparam int unsigned SIDE_RIGHT  = 1;
  localparam int unsigned SIDE_BOTTOM = 2;
  localparam int unsigned SIDE_LEFT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } load_state_e;

  function automatic int unsigned cfg_w(input int unsigned idx_w);
    return idx_w + SEL_W;
  endfunction

endpackage

// File: rtl/sb_route_mux.sv
// One output track: decodes its config entry and picks a source input, or stays off.
module sb_route_mux
  import switch_box_pkg::*;
#(
  parameter int unsigned NTOP     = 5,
  parameter int unsigned NSIDE    = 4,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned OWN_SIDE = 0,
  parameter int unsigned OWN_IDX  = 0
) (
  input  logic [cfg_w(IDX_W)-1:0] entry,
  input  logic [NTOP-1:0]         top_in,
  input  logic [NTOP-1:0]         bot_in,
  input  logic [NSIDE-1:0]        left_in,
  input  logic [NSIDE-1:0]        right_in,
  output logic                    route_out_c,
  output logic                    route_oe_c
);

  logic [SEL_W-1:0] sel;
  logic [IDX_W-1:0] idx;
  logic             hit;
  logic             val;
  logic             self_c;

  assign sel = entry[SEL_W-1:0];
  assign idx = entry[cfg_w(IDX_W)-1:SEL_W];

  // Index loops keep out-of-range indices from ever selecting a bit.
  always_comb begin
    hit         = 1'b0;
    val         = 1'b0;
    self_c      = 1'b0;
    route_out_c = 1'b0;
    route_oe_c  = 1'b0;
    case (sel)
      SEL_OFF: ;
      SEL_TOP: begin
        for (int i = 0; i < int'(NTOP); i++)
          if (idx == IDX_W'(i)) begin hit = 1'b1; val = top_in[i]; end
        self_c = (OWN_SIDE == SIDE_TOP) && (idx == IDX_W'(OWN_IDX));
      end
      SEL_RIGHT: begin
        for (int i = 0; i < int'(NSIDE); i++)
          if (idx == IDX_W'(i)) begin hit = 1'b1; val = right_in[i]; end
        self_c = (OWN_SIDE == SIDE_RIGHT) && (idx == IDX_W'(OWN_IDX));
      end
      SEL_BOTTOM: begin
        for (int i = 0; i < int'(NTOP); i++)
          if (idx == IDX_W'(i)) begin hit = 1'b1; val = bot_in[i]; end
        self_c = (OWN_SIDE == SIDE_BOTTOM) && (idx == IDX_W'(OWN_IDX));
      end
      SEL_LEFT: begin
        for (int i = 0; i < int'(NSIDE); i++)
          if (idx == IDX_W'(i)) begin hit = 1'b1; val = left_in[i]; end
        self_c = (OWN_SIDE == SIDE_LEFT) && (idx == IDX_W'(OWN_IDX));
      end
      default: ;
    endcase
    if (hit && !self_c) begin
      route_oe_c  = 1'b1;
      route_out_c = val;
    end
  end

endmodule

// File: rtl/switch_box_cfg.sv
// Four-sided routing switch box with a serial shadow config chain and qualified commit.
module switch_box_cfg
  import switch_box_pkg::*;
#(
  parameter int unsigned NTOP    = 5,
  parameter int unsigned NSIDE   = 4,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned REG_OUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NTOP-1:0]  top_in,
  input  logic [NTOP-1:0]  bot_in,
  input  logic [NSIDE-1:0] left_in,
  input  logic [NSIDE-1:0] right_in,
  output logic [NTOP-1:0]  top_out,
  output logic [NTOP-1:0]  top_oe,
  output logic [NTOP-1:0]  bot_out,
  output logic [NTOP-1:0]  bot_oe,
  output logic [NSIDE-1:0] left_out,
  output logic [NSIDE-1:0] left_oe,
  output logic [NSIDE-1:0] right_out,
  output logic [NSIDE-1:0] right_oe,
  input  logic             cfg_shift,
  input  logic             cfg_din,
  output logic             cfg_dout,
  input  logic             cfg_commit,
  input  logic             cfg_clr,
  output logic             cfg_full,
  output logic             cfg_err
);

  localparam int unsigned CFG_W      = cfg_w(IDX_W);
  localparam int unsigned NENT       = 2 * NTOP + 2 * NSIDE;
  localparam int unsigned TOTAL_BITS = NENT * CFG_W;
  localparam int unsigned CNT_W      = $clog2(TOTAL_BITS + 1);

  logic [TOTAL_BITS-1:0] shadow_q, shadow_d;
  logic [TOTAL_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, cnt_base;
  logic                  full_q, full_d;
  logic                  err_q, err_d;
  logic                  commit_ok;
  load_state_e           state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      bit_cnt_q <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      bit_cnt_q <= bit_cnt_d;
      full_q    <= full_d;
      err_q     <= err_d;
      state_q   <= state_d;
    end
  end

  // Commit is judged on the pre-edge full flag, so it sees the pre-shift shadow.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    state_d   = state_q;
    commit_ok = cfg_commit && full_q && !cfg_clr;
    if (cfg_shift)
      shadow_d = {cfg_din, shadow_q[TOTAL_BITS-1:1]};
    if (commit_ok)
      active_d = shadow_q;

    cnt_base  = commit_ok ? '0 : bit_cnt_q;
    bit_cnt_d = cnt_base;
    if (cfg_shift && (cnt_base != CNT_W'(TOTAL_BITS)))
      bit_cnt_d = cnt_base + CNT_W'(1);
    if (cfg_clr)
      bit_cnt_d = '0;
    full_d = (bit_cnt_d == CNT_W'(TOTAL_BITS));

    err_d = err_q | (cfg_shift & full_q) | (cfg_commit & ~full_q);
    if (cfg_clr)
      err_d = 1'b0;

    case (state_q)
      ST_IDLE:    if (cfg_shift) state_d = full_d ? ST_FULL : ST_LOADING;
      ST_LOADING: if (full_d) state_d = ST_FULL;
      ST_FULL:    if (commit_ok) state_d = cfg_shift ? ST_LOADING : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (cfg_clr)
      state_d = ST_IDLE;
  end

  assign cfg_dout = shadow_q[0];
  assign cfg_full = full_q;
  assign cfg_err  = err_q;

  logic [NENT-1:0] route_out_c, route_oe_c;
  logic [NENT-1:0] out_vec, oe_vec;

  // Entry order: top, right, bottom, left.
  for (genvar k = 0; k < NENT; k++) begin : g_trk
    localparam int unsigned KU   = k;
    localparam int unsigned SIDE = (KU < NTOP) ? SIDE_TOP :
                                   (KU < NTOP + NSIDE) ? SIDE_RIGHT :
                                   (KU < 2 * NTOP + NSIDE) ? SIDE_BOTTOM : SIDE_LEFT;
    localparam int unsigned BASE = (KU < NTOP) ? 0 :
                                   (KU < NTOP + NSIDE) ? NTOP :
                                   (KU < 2 * NTOP + NSIDE) ? NTOP + NSIDE : 2 * NTOP + NSIDE;
    sb_route_mux #(
      .NTOP(NTOP), .NSIDE(NSIDE), .IDX_W(IDX_W),
      .OWN_SIDE(SIDE), .OWN_IDX(KU - BASE)
    ) u_mux (
      .entry      (active_q[KU*CFG_W +: CFG_W]),
      .top_in     (top_in),
      .bot_in     (bot_in),
      .left_in    (left_in),
      .right_in   (right_in),
      .route_out_c(route_out_c[k]),
      .route_oe_c (route_oe_c[k])
    );
  end

  if (REG_OUT != 0) begin : g_reg
    logic [NENT-1:0] out_d, out_q, oe_d, oe_q;
    always_comb begin
      out_d = route_out_c;
      oe_d  = route_oe_c;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_q <= '0;
        oe_q  <= '0;
      end else begin
        out_q <= out_d;
        oe_q  <= oe_d;
      end
    end
    assign out_vec = out_q;
    assign oe_vec  = oe_q;
  end else begin : g_comb
    assign out_vec = route_out_c;
    assign oe_vec  = route_oe_c;
  end

  assign top_out   = out_vec[0 +: NTOP];
  assign top_oe    = oe_vec[0 +: NTOP];
  assign right_out = out_vec[NTOP +: NSIDE];
  assign right_oe  = oe_vec[NTOP +: NSIDE];
  assign bot_out   = out_vec[NTOP+NSIDE +: NTOP];
  assign bot_oe    = oe_vec[NTOP+NSIDE +: NTOP];
  assign left_out  = out_vec[2*NTOP+NSIDE +: NSIDE];
  assign left_oe   = oe_vec[2*NTOP+NSIDE +: NSIDE];

endmodule

// File: tb/tb_switch_box_cfg.sv
// Scoreboard bench for switch_box_cfg: combinational-output and registered-output instances.
module tb_switch_box_cfg;

  localparam int TB = 108;
  localparam int W_OE = 0, W_OUT = 1, W_TOUT = 2, W_LOUT = 3, W_FULL = 4, W_ERR = 5,
                 W_DOUT = 6, W_TOE1 = 7, W_TOUT1 = 8, W_FULL1 = 9, W_OE1 = 10, W_OUT1 = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cfg_shift, cfg_din, cfg_commit, cfg_clr;
  logic [4:0] top_in, bot_in;
  logic [3:0] left_in, right_in;

  logic [4:0] top_out, top_oe, bot_out, bot_oe;
  logic [3:0] left_out, left_oe, right_out, right_oe;
  logic       cfg_dout, cfg_full, cfg_err;
  logic [4:0] top_out1, top_oe1, bot_out1, bot_oe1;
  logic [3:0] left_out1, left_oe1, right_out1, right_oe1;
  logic       cfg_dout1, cfg_full1, cfg_err1;

  switch_box_cfg #(.NTOP(5), .NSIDE(4), .IDX_W(3), .REG_OUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .top_in(top_in), .bot_in(bot_in), .left_in(left_in), .right_in(right_in),
    .top_out(top_out), .top_oe(top_oe), .bot_out(bot_out), .bot_oe(bot_oe),
    .left_out(left_out), .left_oe(left_oe), .right_out(right_out), .right_oe(right_oe),
    .cfg_shift(cfg_shift), .cfg_din(cfg_din), .cfg_dout(cfg_dout), .cfg_commit(cfg_commit),
    .cfg_clr(cfg_clr), .cfg_full(cfg_full), .cfg_err(cfg_err));

  switch_box_cfg #(.NTOP(5), .NSIDE(4), .IDX_W(3), .REG_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .top_in(top_in), .bot_in(bot_in), .left_in(left_in), .right_in(right_in),
    .top_out(top_out1), .top_oe(top_oe1), .bot_out(bot_out1), .bot_oe(bot_oe1),
    .left_out(left_out1), .left_oe(left_oe1), .right_out(right_out1), .right_oe(right_oe1),
    .cfg_shift(cfg_shift), .cfg_din(cfg_din), .cfg_dout(cfg_dout1), .cfg_commit(cfg_commit),
    .cfg_clr(cfg_clr), .cfg_full(cfg_full1), .cfg_err(cfg_err1));

  typedef struct {
    int          due;
    int          what;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t          sbq[$];
  chk_t          mc;
  logic [31:0]   ma;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic [TB-1:0] cfg_vec;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int w);
    case (w)
      W_OE:    return 32'({left_oe, bot_oe, right_oe, top_oe});
      W_OUT:   return 32'({left_out, bot_out, right_out, top_out});
      W_TOUT:  return 32'(top_out);
      W_LOUT:  return 32'(left_out);
      W_FULL:  return 32'(cfg_full);
      W_ERR:   return 32'(cfg_err);
      W_DOUT:  return 32'(cfg_dout);
      W_TOE1:  return 32'(top_oe1);
      W_TOUT1: return 32'(top_out1);
      W_FULL1: return 32'(cfg_full1);
      W_OE1:   return 32'({left_oe1, bot_oe1, right_oe1, top_oe1});
      W_OUT1:  return 32'({left_out1, bot_out1, right_out1, top_out1, cfg_dout1, cfg_err1});
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compare every scoreboard entry that falls due this cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mc = sbq.pop_front();
      ma = actual(mc.what);
      n_cmp = n_cmp + 1;
      if (ma !== mc.exp) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got %0h, want %0h (cycle %0d)", mc.name, ma, mc.exp, cyc);
      end
    end
  end

  task automatic expect_v(input string nm, input int w, input logic [31:0] e);
    chk_t c;
    c.due  = cyc;
    c.what = w;
    c.exp  = e;
    c.name = nm;
    sbq.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input int idx, input int sel);
    cfg_vec[k*6 +: 6] = {3'(idx), 3'(sel)};
  endtask

  task automatic load(input int start, input int n, input bit commit_last);
    for (int i = 0; i < n; i++) begin
      cfg_shift  = 1'b1;
      cfg_din    = cfg_vec[(start + i) % TB];
      cfg_commit = commit_last && (i == n - 1);
      tick();
    end
    cfg_shift  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic clear();
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_shift = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0; cfg_clr = 1'b0;
    top_in = '0; bot_in = '0; left_in = '0; right_in = '0; cfg_vec = '0;
    tick(); tick();
    rst_n = 1'b1;
    top_in = 5'h1f; bot_in = 5'h1f; left_in = 4'hf; right_in = 4'hf;
    repeat (5) tick();
    expect_v("reset_oe", W_OE, 32'h0);
    expect_v("reset_out", W_OUT, 32'h0);
    expect_v("reset_full", W_FULL, 32'h0);
    expect_v("reset_err", W_ERR, 32'h0);
    expect_v("reset_dout", W_DOUT, 32'h0);
    expect_v("reset_oe_reg", W_OE1, 32'h0);
    expect_v("reset_out_reg", W_OUT1, 32'h0);

    // Route left[2] -> top[0].
    left_in = 4'h0;
    cfg_vec = '0; put(0, 2, 4);
    load(0, 107, 1'b0);
    expect_v("full_at_107", W_FULL, 32'h0);
    load(107, 1, 1'b0);
    expect_v("full_at_108", W_FULL, 32'h1);
    commit();
    expect_v("commit_oe", W_OE, 32'h1);
    expect_v("commit_full_clr", W_FULL, 32'h0);
    expect_v("commit_err", W_ERR, 32'h0);
    left_in = 4'b0100;
    expect_v("route_hi", W_OUT, 32'h1);
    tick(); left_in = 4'b1011;
    expect_v("route_lo", W_TOUT, 32'h0);
    tick(); left_in = 4'b0100;
    expect_v("route_hi2", W_TOUT, 32'h1);

    // Short load commit is rejected.
    load(0, 107, 1'b0);
    commit();
    expect_v("short_commit_err", W_ERR, 32'h1);
    expect_v("short_commit_full", W_FULL, 32'h0);
    expect_v("short_commit_keep", W_OE, 32'h1);
    clear();
    expect_v("clr_err", W_ERR, 32'h0);
    expect_v("clr_full", W_FULL, 32'h0);

    // Illegal entries plus one legal top[4] -> left[3].
    cfg_vec = '0;
    put(8, 7, 1); put(10, 1, 3); put(4, 2, 6); put(0, 0, 1); put(17, 4, 1);
    load(0, TB, 1'b0);
    expect_v("chain_dout", W_DOUT, 32'h1);
    commit();
    expect_v("illegal_oe", W_OE, 32'h20000);
    top_in = 5'h10;
    expect_v("legal_route_hi", W_LOUT, 32'h8);
    tick(); top_in = 5'h0f;
    expect_v("legal_route_lo", W_LOUT, 32'h0);

    // Overshift sets the sticky error.
    load(0, TB + 1, 1'b0);
    expect_v("overshift_full", W_FULL, 32'h1);
    expect_v("overshift_err", W_ERR, 32'h1);
    clear();
    expect_v("overshift_clr", W_ERR, 32'h0);

    // Commit on the 108th shift edge is too early; the next one lands.
    cfg_vec = '0; put(1, 3, 2);
    load(0, TB, 1'b1);
    expect_v("early_commit_err", W_ERR, 32'h1);
    expect_v("early_commit_full", W_FULL, 32'h1);
    expect_v("early_commit_keepA", W_OE, 32'h20000);
    commit();
    expect_v("late_commit_oe", W_OE, 32'h2);
    expect_v("late_commit_full", W_FULL, 32'h0);
    right_in = 4'h8;
    expect_v("late_commit_out", W_OUT, 32'h2);
    clear();

    // Registered-output latency: left[1] -> top[0].
    left_in = 4'h0;
    cfg_vec = '0; put(0, 1, 4);
    load(0, TB, 1'b0);
    commit();
    expect_v("reg_oe_old", W_TOE1, 32'h02);
    tick();
    expect_v("reg_oe_new", W_TOE1, 32'h01);
    left_in = 4'b0010;
    expect_v("comb_follow", W_TOUT, 32'h01);
    expect_v("reg_lag_lo", W_TOUT1, 32'h00);
    tick();
    expect_v("reg_follow_hi", W_TOUT1, 32'h01);
    left_in = 4'b0000;
    expect_v("reg_hold_hi", W_TOUT1, 32'h01);
    expect_v("comb_follow_lo", W_TOUT, 32'h00);
    tick();
    expect_v("reg_follow_lo", W_TOUT1, 32'h00);

    // Reset mid-load discards the partial chain.
    load(0, 50, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_v("midreset_oe", W_OE, 32'h0);
    expect_v("midreset_oe_reg", W_OE1, 32'h0);
    expect_v("midreset_err", W_ERR, 32'h0);
    load(50, 58, 1'b0);
    expect_v("midreset_full", W_FULL, 32'h0);
    expect_v("midreset_full_reg", W_FULL1, 32'h0);
    load(0, 50, 1'b0);
    expect_v("reload_full", W_FULL, 32'h1);

    repeat (3) tick();
    if (sbq.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
      n_cmp = n_cmp + sbq.size();
      n_bad = n_bad + sbq.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
